// File: rtl/par_moody_source.sv
// Random-destination packet source: an LFSR-gated generator feeding a 4-entry FIFO
// that drains into a busy-throttled downstream channel.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module par_moody_source #(
  parameter int         id             = 0,
  parameter int         injection_rate = 0,
  parameter logic [7:0] seed           = 8'hA5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 channel_busy,
  output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0]  item_out,
  output logic                                 valid,
  output logic [15:0]                          drop_count,
  output logic [15:0]                          tx_count
);
  localparam int              PW       = `PAYLOAD_SIZE;
  localparam int              AW       = `ADDR_BITS;
  localparam int              IW       = PW + AW;
  localparam logic [7:0]      SEED_EFF = (seed == 8'h00) ? 8'h01 : seed;
  localparam logic [7:0]      RATE     = 8'(injection_rate);
  localparam logic [AW-1:0]   ID_A     = AW'(id);
  localparam logic [AW-1:0]   ID_NEXT  = AW'(id + 1);

  logic [7:0]    lfsr_q, lfsr_d;
  logic [PW-1:0] seq_q, seq_d;
  logic [1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   drop_q, drop_d, tx_q, tx_d;
  logic [IW-1:0] mem [4];

  logic          gen, full, enq, deq;
  logic [AW-1:0] dest;

  assign gen   = enable && (lfsr_q < RATE);
  assign full  = (cnt_q == 3'd4);
  assign enq   = gen && !full;
  assign valid = (cnt_q != 3'd0);
  assign deq   = valid && !channel_busy;
  // Never address ourselves: bump to the next node instead.
  assign dest  = (lfsr_q[AW-1:0] == ID_A) ? ID_NEXT : lfsr_q[AW-1:0];

  // Masking by valid keeps item_out at zero while the queue is empty or in reset.
  assign item_out   = valid ? mem[rd_q] : '0;
  assign drop_count = drop_q;
  assign tx_count   = tx_q;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    seq_d  = gen ? seq_q + PW'(1) : seq_q;
    wr_d   = enq ? wr_q + 2'd1 : wr_q;
    rd_d   = deq ? rd_q + 2'd1 : rd_q;
    tx_d   = deq ? tx_q + 16'd1 : tx_q;
    drop_d = drop_q;
    if (gen && full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    cnt_d  = cnt_q;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED_EFF;
      seq_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      tx_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      seq_q  <= seq_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      tx_q   <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_q] <= {seq_q, dest};
  end
endmodule

// File: doc/par_moody_source.md
PAR_MOODY_SOURCE -- requirements
Module: par_moody_source

Interface
- REQ-001: Parameter `id`, default 0: own node address; never used as a destination.
- REQ-002: Parameter `injection_rate`, default 0: 0..255, injection threshold; 0 means never inject.
- REQ-003: Parameter `seed`, default 8'hA5: LFSR reset value; a seed of 0 SHALL be replaced by 8'h01.
- REQ-004: Widths SHALL come from the global defines `PAYLOAD_SIZE` and `ADDR_BITS`. Item format: {payload[`PAYLOAD_SIZE-1:0], dest[`ADDR_BITS-1:0]}.
- REQ-005: clk, input, 1: single clock; all state updates on its rising edge.
- REQ-006: reset, input, 1: asynchronous, active-low (0 = reset).
- REQ-007: enable, input, 1: 1 permits packet generation; 0 stops generation, but the queue still drains.
- REQ-008: channel_busy, input, 1: downstream sink busy; no transfer while high.
- REQ-009: item_out, output, `PAYLOAD_SIZE+`ADDR_BITS: head-of-queue item.
- REQ-010: valid, output, 1: item_out holds a pending item.
- REQ-011: drop_count, output, 16: number of packets generated while the queue was full; saturating.
- REQ-012: tx_count, output, 16: number of items transferred downstream; wraps.

Function
- REQ-013: The block SHALL hold an 8-bit Fibonacci LFSR with taps 8,6,5,4. It SHALL advance once every cycle out of reset, independent of enable.
- REQ-014: Generation event: a cycle with enable=1 and current LFSR value < injection_rate (unsigned compare).
- REQ-015: Destination SHALL be lfsr[`ADDR_BITS-1:0]. If that equals id, the destination SHALL be id+1 modulo 2^`ADDR_BITS.
- REQ-016: Payload SHALL be a `PAYLOAD_SIZE`-bit sequence counter. It SHALL increment on every generation event, including dropped ones, and wrap to 0.
- REQ-017: The queue SHALL be a 4-entry FIFO with 2-bit read/write pointers and a 3-bit occupancy count (0..4).
- REQ-018: valid SHALL be combinationally (occupancy != 0). item_out SHALL be the entry at the read pointer.
- REQ-019: Transfer: a cycle with valid=1 and channel_busy=0. The read pointer SHALL advance and tx_count SHALL increment at that edge.
- REQ-020: While valid=1 and channel_busy=1, item_out SHALL stay stable and no state other than the LFSR, sequence counter and enqueue path SHALL change.
- REQ-021: A generation event when the pre-edge occupancy is < 4 SHALL write at the write pointer. The item SHALL be visible on item_out no earlier than the next cycle (latency 1 when the queue is empty).
- REQ-022: A generation event when the pre-edge occupancy is 4 SHALL be dropped, even if a transfer occurs in the same cycle. drop_count SHALL increment, saturating at 16'hFFFF.
- REQ-023: Simultaneous enqueue and transfer SHALL leave occupancy unchanged. Pointers SHALL wrap 3->0.
- REQ-024: Order of items out SHALL equal order of enqueue; no item SHALL be duplicated or lost other than per REQ-022.
- REQ-025: Deasserting enable SHALL NOT flush the queue. Pending items SHALL still transfer.

Reset
- REQ-026: Asserting reset (0) at any time, including mid-transfer, SHALL immediately clear the FIFO pointers, occupancy, sequence counter, drop_count and tx_count, and load the LFSR with seed.
- REQ-027: During reset: valid=0, item_out=0, drop_count=0, tx_count=0. Queue contents SHALL be don't-care but masked by valid=0.
- REQ-028: The first generation event is possible on the first rising edge after reset deasserts.

Verification
- REQ-029: injection_rate=0, enable=1, channel_busy=0 for 1000 cycles -> valid stays 0, tx_count=0, drop_count=0.
- REQ-030: injection_rate=255, channel_busy=0, `ADDR_BITS`=4, id=3 -> packets carry payload 0,1,2,... in order, no dest equals 3, drop_count=0.
- REQ-031: injection_rate=255, channel_busy=1 for 10 cycles -> occupancy reaches 4 after 4 cycles, drop_count=6, item_out constant with payload 0.
- REQ-032: Queue full, then channel_busy=0 with a generation event in the same cycle -> one transfer, the new packet dropped, occupancy=3, drop_count increments by 1.
- REQ-033: reset pulsed low mid-stream for 1 cycle asynchronously to clk -> valid drops to 0 immediately; after release, the first payload is 0 and the LFSR sequence repeats from seed.
- REQ-034: A scoreboard connected to a sink that holds busy high randomly SHALL see every non-dropped packet exactly once, in order.
